// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bi, one bit per clock, LSB first.
// A single borrow flip-flop ripples between bit slices; done pulses for one cycle per result.
module serial_subtractor #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            bi,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] diff,
  output logic            bo
);

  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_res;
  logic            r_brw;
  logic [CW-1:0]   r_cnt;

  logic            w_a;
  logic            w_b;
  logic            w_d;
  logic            w_brw_next;
  logic [SIZE-1:0] w_res_next;
  logic            w_last;

  // Operand registers shift right, so bit cnt of the original operand is always at bit 0.
  assign w_a        = r_a[0];
  assign w_b        = r_b[0];
  assign w_d        = w_a ^ w_b ^ r_brw;
  assign w_brw_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_brw);
  assign w_res_next = {w_d, r_res[SIZE-1:1]};
  assign w_last     = (r_cnt == CW'(SIZE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bo      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_brw   <= bi;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_brw <= w_brw_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            diff    <= w_res_next;
            bo      <= w_brw_next;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at SIZE=8 against hand values and a parallel reference.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bi;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bo;

  int checks;
  int errors;

  serial_subtractor #(.SIZE(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bo    (bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation from IDLE and follow it to its done cycle, then one more edge back to IDLE.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbi,
                       output logic [7:0] od, output logic obo,
                       output int lat, output int bcyc, output int early_chg);
    logic [7:0] pd;
    logic       pb;
    a = ta; b = tb_v; bi = tbi; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
    pd = diff; pb = bo;
    lat = 0; bcyc = 0; early_chg = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      if (diff !== pd || bo !== pb) early_chg++;
      step();
      lat++;
    end
    if (busy) bcyc++;
    od = diff; obo = bo;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    repeat (3) step();
    checks++;
    if ({busy, done, diff, bo} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold: busy=%b done=%b diff=%h bo=%b required all 0", busy, done, diff, bo);
    end
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({busy, done, diff, bo} !== 11'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b done=%b diff=%h bo=%b required all 0", busy, done, diff, bo);
    end
  endtask

  task automatic test_nominal();
    logic [7:0] d; logic o; int lat, bc, ec;
    do_op(8'h5A, 8'h23, 1'b0, d, o, lat, bc, ec);
    checks++;
    if (d !== 8'h37 || o !== 1'b0) begin
      errors++;
      $display("FAIL nominal_result: diff=%h bo=%b required diff=37 bo=0", d, o);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL nominal_latency: done %0d edges after acceptance required 8", lat);
    end
    checks++;
    if (bc !== 9) begin
      errors++;
      $display("FAIL nominal_busy: busy high %0d cycles required 9", bc);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h37) begin
      errors++;
      $display("FAIL nominal_after: busy=%b done=%b diff=%h required 0 0 37", busy, done, diff);
    end
  endtask

  task automatic test_borrow();
    logic [7:0] va [3] = '{8'h00, 8'h10, 8'hFF};
    logic [7:0] vb [3] = '{8'h01, 8'h10, 8'h00};
    logic       vi [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ed [3] = '{8'hFF, 8'hFF, 8'hFE};
    logic       eo [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0] d; logic o; int lat, bc, ec;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vi[i], d, o, lat, bc, ec);
      checks++;
      if (d !== ed[i] || o !== eo[i]) begin
        errors++;
        $display("FAIL borrow_%0d: diff=%h bo=%b required diff=%h bo=%b", i, d, o, ed[i], eo[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int n_done, cyc;
    a = 8'h80; b = 8'h01; bi = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n_done = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 3) begin a = 8'h00; b = 8'h00; start = 1'b1; end
      else if (!done) start = 1'b0;
      if (done) begin
        n_done++;
        checks++;
        if (diff !== 8'h7F || bo !== 1'b0) begin
          errors++;
          $display("FAIL busy_ignore_result: diff=%h bo=%b required diff=7F bo=0", diff, bo);
        end
        start = 1'b1;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (n_done !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_count: done pulses=%0d busy=%b required 1 and 0", n_done, busy);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] d; logic o; int lat, bc, ec, n_done;
    a = 8'h44; b = 8'h11; bi = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, bo} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_async: busy=%b done=%b diff=%h bo=%b required all 0", busy, done, diff, bo);
    end
    step();
    #2 rst_n = 1'b1;
    n_done = 0;
    repeat (15) begin
      step();
      if (done || busy) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: busy/done seen %0d cycles required 0", n_done);
    end
    do_op(8'h03, 8'h05, 1'b0, d, o, lat, bc, ec);
    checks++;
    if (d !== 8'hFE || o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next: diff=%h bo=%b required diff=FE bo=1", d, o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [3] = '{8'h12, 8'hC8, 8'h01};
    logic [7:0] vb [3] = '{8'h34, 8'h64, 8'h01};
    logic       vi [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ed [3] = '{8'hDE, 8'h63, 8'hFF};
    logic       eo [3] = '{1'b1, 1'b0, 1'b1};
    int k, cyc, last;
    a = va[0]; b = vb[0]; bi = vi[0]; start = 1'b1;
    step();
    k = 0; last = -1;
    for (cyc = 1; cyc < 60 && k < 3; cyc++) begin
      if (done) begin
        checks++;
        if (diff !== ed[k] || bo !== eo[k]) begin
          errors++;
          $display("FAIL b2b_result_%0d: diff=%h bo=%b required diff=%h bo=%b", k, diff, bo, ed[k], eo[k]);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 10) begin
            errors++;
            $display("FAIL b2b_spacing_%0d: done spacing %0d required 10", k, cyc - last);
          end
        end
        last = cyc;
        k++;
        if (k < 3) begin a = va[k]; b = vb[k]; bi = vi[k]; end
        else start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL b2b_count: done pulses %0d required 3", k);
    end
    repeat (12) step();
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, d; logic rbi, o; logic [8:0] ref_v;
    int lat, bc, ec, bad, bad_t, bad_s;
    bad = 0; bad_t = 0; bad_s = 0;
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      if (i == 0) begin ra = 8'h00; rb = 8'hFF; rbi = 1'b1; end
      if (i == 1) begin ra = 8'hFF; rb = 8'hFF; rbi = 1'b0; end
      ref_v = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
      do_op(ra, rb, rbi, d, o, lat, bc, ec);
      if (d !== ref_v[7:0] || o !== ref_v[8]) begin
        if (bad == 0)
          $display("FAIL random_result: a=%h b=%h bi=%b diff=%h bo=%b required diff=%h bo=%b",
                   ra, rb, rbi, d, o, ref_v[7:0], ref_v[8]);
        bad++;
      end
      if (lat !== 8 || bc !== 9) bad_t++;
      if (ec !== 0) bad_s++;
      repeat ($urandom_range(0, 3)) step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL random_results: %0d mismatching ops required 0", bad);
    end
    checks++;
    if (bad_t !== 0) begin
      errors++;
      $display("FAIL random_timing: %0d ops with wrong latency/busy required 0", bad_t);
    end
    checks++;
    if (bad_s !== 0) begin
      errors++;
      $display("FAIL random_stability: %0d ops where diff/bo moved before done required 0", bad_s);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nominal();
    test_borrow();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
